// File: rtl/dm_arbiter_pkg.sv
// Shared helpers for the data_mem arbiter: core-count limit and index utilities.
// Width macros normally arrive from the shared defines.v; the guards cover standalone builds.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef DM_ADDR_WIDTH
`define DM_ADDR_WIDTH 10
`endif

package dm_arbiter_pkg;

    localparam int MAX_CORES = 8;

    // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
    function automatic int onehot_to_idx(input logic [MAX_CORES-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CORES; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int next_idx(input int k, input int n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority selector: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates NUM_CORES cpu_core requesters onto one data_mem port with bus lock
// for read-modify-write and a fixed-latency read-return pipeline.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DW         = `DATAWIDTH,
    parameter int AW         = `DM_ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    req_i,
    input  logic [NUM_CORES-1:0]    we_i,
    input  logic [NUM_CORES-1:0]    lock_i,
    input  logic [NUM_CORES*AW-1:0] addr_i,
    input  logic [NUM_CORES*DW-1:0] din_i,
    output logic [NUM_CORES-1:0]    gnt_o,
    output logic [NUM_CORES-1:0]    rvalid_o,
    output logic [DW-1:0]           rdata_o,
    output logic                    mem_we_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DW-1:0]           mem_din_o,
    input  logic [DW-1:0]           mem_dout_i
);

    localparam int PW = $clog2(NUM_CORES);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]        owner, owner_nxt;
    logic [CW-1:0]        lock_cnt, lock_cnt_nxt;
    logic [NUM_CORES-1:0] relock_blk, relock_blk_nxt;
    logic [NUM_CORES-1:0] rr_gnt, gnt, owner_oh;
    int                   rr_idx, gnt_idx;

    logic                 rd_valid [RD_LATENCY];
    logic [PW-1:0]        rd_id    [RD_LATENCY];

    rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_rr (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    assign rr_idx = onehot_to_idx(MAX_CORES'(rr_gnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            lock_cnt   <= '0;
            relock_blk <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner      <= owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
            relock_blk <= relock_blk_nxt;
        end
    end

    // A core that hit LOCK_MAX is barred from re-locking until it wins one unlocked grant.
    always_comb begin
        gnt            = '0;
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        owner_nxt      = owner;
        lock_cnt_nxt   = lock_cnt;
        relock_blk_nxt = relock_blk;
        owner_oh       = '0;
        owner_oh[owner] = 1'b1;
        case (state)
            IDLE: begin
                if (|rr_gnt) begin
                    gnt = rr_gnt;
                    if ((lock_i & ~relock_blk & rr_gnt) != '0) begin
                        if (LOCK_MAX > 1) begin
                            state_nxt    = LOCKED;
                            owner_nxt    = PW'(rr_idx);
                            lock_cnt_nxt = CW'(1);
                        end else begin
                            rr_ptr_nxt     = PW'(next_idx(rr_idx, NUM_CORES));
                            relock_blk_nxt = relock_blk | rr_gnt;
                        end
                    end else begin
                        rr_ptr_nxt     = PW'(next_idx(rr_idx, NUM_CORES));
                        relock_blk_nxt = relock_blk & ~rr_gnt;
                    end
                end
            end
            LOCKED: begin
                if (req_i[owner]) begin
                    gnt = owner_oh;
                    if (!lock_i[owner]) begin
                        state_nxt    = IDLE;
                        lock_cnt_nxt = '0;
                        rr_ptr_nxt   = PW'(next_idx(int'(owner), NUM_CORES));
                    end else if (lock_cnt == CW'(LOCK_MAX - 1)) begin
                        state_nxt      = IDLE;
                        lock_cnt_nxt   = '0;
                        rr_ptr_nxt     = PW'(next_idx(int'(owner), NUM_CORES));
                        relock_blk_nxt = relock_blk | owner_oh;
                    end else begin
                        lock_cnt_nxt = lock_cnt + CW'(1);
                    end
                end else begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_o      = rst ? '0 : gnt;
        gnt_idx    = onehot_to_idx(MAX_CORES'(gnt_o));
        mem_we_o   = |(gnt_o & we_i);
        mem_addr_o = (|gnt_o) ? addr_i[gnt_idx*AW +: AW] : '0;
        mem_din_o  = (|gnt_o) ? din_i[gnt_idx*DW +: DW] : '0;
    end

    // Read tags travel alongside data_mem's latency; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_valid[i] <= 1'b0;
                rd_id[i]    <= '0;
            end
        end else begin
            rd_valid[0] <= |(gnt_o & ~we_i);
            rd_id[0]    <= PW'(gnt_idx);
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_valid[i] <= rd_valid[i-1];
                rd_id[i]    <= rd_id[i-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rd_valid[RD_LATENCY-1]) begin
            rvalid_o[rd_id[RD_LATENCY-1]] = 1'b1;
            rdata_o                       = mem_dout_i;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: 4-core/latency-1 instance plus a 2-core/latency-3 instance.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  req, we, lock;
    logic [39:0] addr;
    logic [127:0] din;
    logic [3:0]  gnt, rvalid;
    logic [31:0] rdata, mem_din, mem_dout;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem [1024];

    logic [1:0]  req2, we2, lock2;
    logic [19:0] addr2;
    logic [63:0] din2;
    logic [1:0]  gnt2, rvalid2;
    logic [31:0] rdata2, mem_din2, mem_dout2, d1, d2;
    logic        mem_we2;
    logic [9:0]  mem_addr2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.NUM_CORES(4), .DW(32), .AW(10), .RD_LATENCY(1), .LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr), .din_i(din), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    dm_arbiter #(.NUM_CORES(2), .DW(32), .AW(10), .RD_LATENCY(3), .LOCK_MAX(16)) dut2 (
        .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .lock_i(lock2),
        .addr_i(addr2), .din_i(din2), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
        .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_din_o(mem_din2), .mem_dout_i(mem_dout2)
    );

    // data_mem stand-ins: one-cycle RAM, and a three-stage echo of the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
        d1        <= {22'b0, mem_addr2};
        d2        <= d1;
        mem_dout2 <= d2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
        req  = r;
        we   = w;
        lock = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    logic [3:0]  exp_rv  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  r2_req  [7] = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0]  r2_gnt  [7] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0]  r2_rv   [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [31:0] r2_data [7] = '{32'h0, 32'h0, 32'h0, 32'h0AA, 32'h155, 32'h0AA, 32'h0};
    logic [3:0]  post_lock [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        rst = 1'b1;
        applyStimulus(4'hF, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            addr[k*10 +: 10] = 10'h100 + 10'(k);
            din[k*32 +: 32]  = 32'h1000 + 32'(k);
        end
        req2 = 2'b00; we2 = 2'b00; lock2 = 2'b00;
        addr2 = {10'h155, 10'h0AA};
        din2  = '0;

        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_din", mem_din, 32'h0);
        step();
        rst = 1'b0;

        // all four cores streaming reads
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i < 5) ? 4'hF : 4'h0, 4'h0, 4'h0);
            #2;
            checkOutput($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(exp_gnt[i]));
            checkOutput($sformatf("rr%0d_rvalid", i), 32'(rvalid), 32'(exp_rv[i]));
            step();
        end

        // core 2 writes, core 0 reads it back
        addr[20 +: 10] = 10'h010;
        din[64 +: 32]  = 32'hDEADBEEF;
        applyStimulus(4'b0100, 4'b0100, 4'h0);
        #2;
        checkOutput("wr_gnt", 32'(gnt), 32'h4);
        checkOutput("wr_mem_we", 32'(mem_we), 32'h1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h010);
        checkOutput("wr_mem_din", mem_din, 32'hDEADBEEF);
        step();
        addr[0 +: 10] = 10'h010;
        applyStimulus(4'b0001, 4'h0, 4'h0);
        #2;
        checkOutput("rd_gnt", 32'(gnt), 32'h1);
        checkOutput("rd_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h010);
        checkOutput("wr_no_rvalid", 32'(rvalid), 32'h0);
        step();
        applyStimulus(4'h0, 4'h0, 4'h0);
        #2;
        checkOutput("rd_rvalid", 32'(rvalid), 32'h1);
        checkOutput("rd_rdata", rdata, 32'hDEADBEEF);
        checkOutput("idle_mem_addr", 32'(mem_addr), 32'h0);
        step();

        // lone core 3, pointer wrap
        applyStimulus(4'b1000, 4'h0, 4'h0);
        #2;
        checkOutput("c3_first_gnt", 32'(gnt), 32'h8);
        step();
        applyStimulus(4'b1000, 4'h0, 4'h0);
        #2;
        checkOutput("c3_ptr0_gnt", 32'(gnt), 32'h8);
        step();
        applyStimulus(4'hF, 4'h0, 4'h0);
        #2;
        checkOutput("wrap_gnt", 32'(gnt), 32'h1);
        step();

        // core 1 holds lock against competing requests
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'hF, 4'h0, 4'b0010);
            #2;
            checkOutput($sformatf("lock%0d_gnt", i), 32'(gnt), 32'h2);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hF, 4'h0, 4'b0010);
            #2;
            checkOutput($sformatf("postlock%0d_gnt", i), 32'(gnt), 32'(post_lock[i]));
            step();
        end
        applyStimulus(4'h0, 4'h0, 4'h0);
        step();

        // reset one cycle after a read grant
        applyStimulus(4'b0001, 4'h0, 4'h0);
        #2;
        checkOutput("prerst_gnt", 32'(gnt), 32'h1);
        step();
        rst = 1'b1;
        applyStimulus(4'hF, 4'hF, 4'h0);
        #2;
        checkOutput("midrst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("midrst_gnt", 32'(gnt), 32'h0);
        checkOutput("midrst_rdata", rdata, 32'h0);
        checkOutput("midrst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("midrst_mem_din", mem_din, 32'h0);
        step();
        step();
        rst = 1'b0;
        applyStimulus(4'b0110, 4'h0, 4'h0);
        #2;
        checkOutput("postrst_gnt", 32'(gnt), 32'h2);
        checkOutput("postrst_rvalid", 32'(rvalid), 32'h0);
        step();
        applyStimulus(4'h0, 4'h0, 4'h0);
        #2;
        checkOutput("postrst_rd_rvalid", 32'(rvalid), 32'h2);
        step();

        // two cores, three-cycle read latency
        for (int i = 0; i < 7; i++) begin
            req2 = r2_req[i];
            #2;
            checkOutput($sformatf("lat3_c%0d_gnt", i), 32'(gnt2), 32'(r2_gnt[i]));
            checkOutput($sformatf("lat3_c%0d_rvalid", i), 32'(rvalid2), 32'(r2_rv[i]));
            checkOutput($sformatf("lat3_c%0d_rdata", i), rdata2, r2_data[i]);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
